// File: rtl/qarma_req_arbiter_if.sv
// Bundle of requester, response and core-side signals of the two-port QARMA arbiter.
// slave = arbiter side, master = surrounding system (request queues, consumer and core).
interface qarma_req_arbiter_if #(
    parameter int N = 64
);
    logic           req0_valid;
    logic           req0_ready;
    logic           req0_enc;
    logic [2*N-1:0] req0_key;
    logic [2*N-1:0] req0_tweak;
    logic [N-1:0]   req0_data;

    logic           req1_valid;
    logic           req1_ready;
    logic           req1_enc;
    logic [2*N-1:0] req1_key;
    logic [2*N-1:0] req1_tweak;
    logic [N-1:0]   req1_data;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [N-1:0]   rsp_data;

    logic           core_enc;
    logic [N-1:0]   core_K0;
    logic [N-1:0]   core_K1;
    logic [N-1:0]   core_P;
    logic [N-1:0]   core_T0;
    logic [N-1:0]   core_T1;
    logic [N-1:0]   core_C;

    modport slave (
        input  req0_valid, req0_enc, req0_key, req0_tweak, req0_data,
        input  req1_valid, req1_enc, req1_key, req1_tweak, req1_data,
        input  rsp_ready, core_C,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        output core_enc, core_K0, core_K1, core_P, core_T0, core_T1
    );

    modport master (
        output req0_valid, req0_enc, req0_key, req0_tweak, req0_data,
        output req1_valid, req1_enc, req1_key, req1_tweak, req1_data,
        output rsp_ready, core_C,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        input  core_enc, core_K0, core_K1, core_P, core_T0, core_T1
    );
endinterface

// File: rtl/qarma_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency QARMAv2-64 core between two requesters.
// Optional per-requester completion counters are enabled by defining QARMA_ARB_STATS_EN.
module qarma_req_arbiter #(
    parameter int N       = 64,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    qarma_req_arbiter_if.slave bus
`ifdef QARMA_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat0_cnt,
    output logic [CNT_W-1:0] stat1_cnt
`endif
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           rr_ptr;
    logic           id;
    logic [CW-1:0]  cnt;

    logic           grant;
    logic           accept;
    logic           ready0;
    logic           ready1;

    logic           sel_enc;
    logic [N-1:0]   sel_k0, sel_k1, sel_t0, sel_t1, sel_p;

    logic           core_enc_q;
    logic [N-1:0]   core_k0_q, core_k1_q, core_t0_q, core_t1_q, core_p_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [N-1:0]   rsp_data_q;

    // Ready is gated by rst so that every output reads 0 while reset is asserted.
    always_comb begin
        state_next = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        accept     = 1'b0;
        grant      = rr_ptr;
        if (!(rr_ptr ? bus.req1_valid : bus.req0_valid)) begin
            grant = ~rr_ptr;
        end
        case (state)
            IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && !rst) begin
                    accept     = 1'b1;
                    ready0     = ~grant;
                    ready1     = grant;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(LATENCY)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_enc = grant ? bus.req1_enc : bus.req0_enc;
        sel_k0  = grant ? bus.req1_key[N-1:0]     : bus.req0_key[N-1:0];
        sel_k1  = grant ? bus.req1_key[2*N-1:N]   : bus.req0_key[2*N-1:N];
        sel_t0  = grant ? bus.req1_tweak[N-1:0]   : bus.req0_tweak[N-1:0];
        sel_t1  = grant ? bus.req1_tweak[2*N-1:N] : bus.req0_tweak[2*N-1:N];
        sel_p   = grant ? bus.req1_data : bus.req0_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Core operands change only on accept, so the core sees no toggling between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            id          <= 1'b0;
            cnt         <= '0;
            core_enc_q  <= 1'b0;
            core_k0_q   <= '0;
            core_k1_q   <= '0;
            core_t0_q   <= '0;
            core_t1_q   <= '0;
            core_p_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_enc_q <= sel_enc;
                        core_k0_q  <= sel_k0;
                        core_k1_q  <= sel_k1;
                        core_t0_q  <= sel_t0;
                        core_t1_q  <= sel_t1;
                        core_p_q   <= sel_p;
                        id         <= grant;
                        cnt        <= '0;
                        rr_ptr     <= ~grant;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(LATENCY)) begin
                        rsp_data_q  <= bus.core_C;
                        rsp_id_q    <= id;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.core_enc   = core_enc_q;
    assign bus.core_K0    = core_k0_q;
    assign bus.core_K1    = core_k1_q;
    assign bus.core_T0    = core_t0_q;
    assign bus.core_T1    = core_t1_q;
    assign bus.core_P     = core_p_q;

`ifdef QARMA_ARB_STATS_EN
    // Completed responses per requester, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            if (!rsp_id_q && (stat0_cnt != {CNT_W{1'b1}})) begin
                stat0_cnt <= stat0_cnt + CNT_W'(1);
            end
            if (rsp_id_q && (stat1_cnt != {CNT_W{1'b1}})) begin
                stat1_cnt <= stat1_cnt + CNT_W'(1);
            end
        end
    end
`endif
endmodule
